// File: rtl/reg_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipeline_pkg
// Description : Shared types and helpers for reg_pipeline.
//               mode_e selects the input transform. xform_bit computes one
//               output bit of that transform, so the top level can build a
//               word of any WIDTH from a per-bit generate loop.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pipeline_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_INV   = 2'b01,
        MODE_DELTA = 2'b10,
        MODE_SWAP  = 2'b11
    } mode_e;

    // One bit of the transform.
    //   d     : in_data bit i
    //   p     : prev bit i (raw in_data of the previously accepted word)
    //   d_rev : in_data bit WIDTH-1-i (mirror bit, used by SWAP)
    function automatic logic xform_bit(input mode_e m, input logic d,
                                       input logic p, input logic d_rev);
        logic r;
        r = d;
        case (m)
            MODE_PASS:  r = d;
            MODE_INV:   r = ~d;
            MODE_DELTA: r = d ^ p;
            MODE_SWAP:  r = d_rev;
            default:    r = d;
        endcase
        return r;
    endfunction

endpackage : reg_pipeline_pkg
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_stage
// Description : One elastic register stage (valid bit + data register).
//               Loads when empty or when its current word leaves in the same
//               cycle, so bubbles collapse through a chain of these stages.
// Ports       : clk, rst (async, active-low), flush (sync clear of valid)
//               up_valid/up_ready/up_data : upstream handshake
//               dn_valid/dn_ready/dn_data : downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Ready is combinational from dn_ready: a full stage whose word is
    // leaving this cycle can take a new one.
    assign up_ready = !r_valid || dn_ready;
    assign dn_valid = r_valid;
    assign dn_data  = r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (up_valid && up_ready) begin
            r_valid <= 1'b1;
            r_data  <= up_data;
        end else if (dn_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : reg_pipe_stage
`default_nettype wire

// File: rtl/reg_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipeline
// Description : Elastic WIDTH-bit register pipeline of DEPTH stages with a
//               valid/ready handshake, per-word input transform, synchronous
//               flush and occupancy count.
// Ports       : clk, rst (async, active-low), flush (sync clear)
//               mode     : input transform, sampled on accept
//               in_valid/in_ready/in_data    : upstream handshake
//               out_valid/out_ready/out_data : downstream handshake
//               count    : number of valid stages (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] c_one = CW'(1);

    logic             w_valid    [DEPTH];
    logic             w_up_ready [DEPTH];
    logic [WIDTH-1:0] w_data     [DEPTH];
    logic [WIDTH-1:0] w_xform;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]    r_count;

    // Flush and reset both block acceptance so the flush cycle cannot load
    // stage 0 or update prev.
    assign in_ready  = !flush && rst && w_up_ready[0];
    assign w_accept  = in_valid && in_ready;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign w_deliver = out_valid && out_ready;
    assign count     = r_count;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_xform
            assign w_xform[i] = xform_bit(mode_e'(mode), in_data[i],
                                          r_prev[i], in_data[WIDTH-1-i]);
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             w_in_valid;
            logic [WIDTH-1:0] w_in_data;
            logic             w_dn_ready;

            if (k == 0) begin : g_first
                assign w_in_valid = w_accept;
                assign w_in_data  = w_xform;
            end else begin : g_mid
                assign w_in_valid = w_valid[k-1];
                assign w_in_data  = w_data[k-1];
            end

            if (k == DEPTH-1) begin : g_last
                assign w_dn_ready = out_ready;
            end else begin : g_inner
                assign w_dn_ready = w_up_ready[k+1];
            end

            reg_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (w_in_valid),
                .up_ready (w_up_ready[k]),
                .up_data  (w_in_data),
                .dn_valid (w_valid[k]),
                .dn_ready (w_dn_ready),
                .dn_data  (w_data[k])
            );
        end
    endgenerate

    // prev tracks the raw (untransformed) input of every accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
        end else if (flush) begin
            r_prev <= '0;
        end else if (w_accept) begin
            r_prev <= in_data;
        end
    end

    // Occupancy follows the stage valid bits: +1 on accept, -1 on deliver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept && !w_deliver) begin
            r_count <= r_count + c_one;
        end else if (!w_accept && w_deliver) begin
            r_count <= r_count - c_one;
        end
    end

endmodule : reg_pipeline
`default_nettype wire

// File: doc/reg_pipeline.md
# reg_pipeline

Parametrised elastic register pipeline that replaces the fixed 8-bit flop bank in the `top` netlist. It carries WIDTH-bit words through DEPTH register stages under a valid/ready handshake, applies a per-word transform at the input, supports synchronous flush, and reports occupancy. It sits between synthesized combinational clusters wherever a registered, back-pressurable datapath is needed.

## Interface
- WIDTH, 8, data word width (1..64)
- DEPTH, 2, number of register stages (1..8)
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- flush  input  1  synchronous clear of all stages and transform state
- mode  input  2  input transform, sampled with each accepted word
- in_valid  input  1  upstream word valid
- in_ready  output  1  pipeline can accept this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  stage DEPTH-1 holds a word
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  word in stage DEPTH-1
- count  output  CW  number of valid stages (0..DEPTH)

## Operation
- Accept: in_valid & in_ready at a rising edge. Deliver: out_valid & out_ready.
- Transform applied to in_data at accept, result written to stage 0:
  - 00 PASS: in_data
  - 01 INV: ~in_data
  - 10 DELTA: in_data ^ prev, where prev is the raw in_data of the previous accepted word
  - 11 SWAP: bit-reversed in_data
- prev updates on every accept, whatever the mode. Reset and flush clear it to 0.
- Each stage holds a valid bit and a data register. A word advances into stage k+1 when stage k+1 is empty or is advancing in the same cycle. Bubbles collapse, so a stalled tail never blocks words behind an empty stage.
- in_ready = !flush & rst & (stage 0 empty | stage 0 advancing). The ready path is combinational from out_ready through the stage chain.
- Ordering is strictly FIFO. No word is dropped or duplicated except by flush.
- count = popcount of stage valid bits, registered with the stages.
- Flush: on the next edge all valid bits, prev and count clear. in_ready is 0 during the flush cycle, so nothing is accepted. Flush beats a simultaneous accept. A word delivered in the flush cycle counts as delivered.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, prev=0, all stage data=0. in_ready=0 while rst=0 and 1 in the first cycle after release.
- Latency: a word accepted at edge t appears on out_data/out_valid after edge t+DEPTH-1 (DEPTH edges including the accept), with no backpressure.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Full: count==DEPTH and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1, and simultaneous accept and deliver keep count unchanged.
- Empty: out_valid=0, and out_data holds its last value (not checked).
- out_data/out_valid must stay stable while out_valid=1 and out_ready=0.
- rst asserted mid-operation clears every stage immediately, asynchronously. The first accept after release uses prev=0 in DELTA mode.
- DEPTH=1: a single stage. in_ready = !valid | out_ready.

## Structure
- Package reg_pipeline_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_PASS, MODE_INV, MODE_DELTA, MODE_SWAP}
  - function for the transform
- Sub-module reg_pipe_stage (WIDTH): one valid/data register pair with async active-low reset. It has upstream and downstream valid/ready ports and a flush input. It is instantiated DEPTH times in a generate loop.
- Top level holds the transform, the prev register and the count logic.

## Test plan
- Reset: hold rst=0 three cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0. Release -> in_ready=1.
- Streaming (WIDTH=8, DEPTH=2, PASS): accept 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> outputs appear 2 edges after each accept, in order, one per cycle, count peaks at 2.
- Modes: INV on 0x0F -> 0xF0. SWAP on 0x01 -> 0x80. DELTA with 0xA5 then 0xFF -> 0xA5 then 0x5A.
- Backpressure: out_ready=0, push 0x01,0x02,0x03 -> two accepted, count=2, in_ready=0, out_data held at 0x01. Raise out_ready -> 0x01,0x02 delivered, then 0x03 accepted.
- Flush: with count=2, assert flush together with in_valid=1 and in_data=0x77 -> 0x77 not accepted. Next cycle count=0, out_valid=0. DELTA with 0x0C then gives 0x0C.
- Async reset mid-stream: drop rst between edges with count=2 -> out_valid and count are 0 before the next edge, and nothing stale is output after release.
